sat_add_sched: RTL and testbench

Round-robin scheduler that shares one unsigned saturating adder (sum = a + b, clamped to all-ones on carry-out) between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes the saturated sum into a single registered response slot tagged with the requester ID, and keeps a saturation event counter. It sits between the per-channel accumulation front-ends and the shared arithmetic resource.

---
 rtl/sat_add_pkg.sv | 23 ++
 rtl/sat_add_sched_rr_arb.sv | 29 ++
 rtl/sat_add_sched.sv | 73 +++++++
 tb/tb_sat_add_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_add_pkg.sv
// Shared types and the saturating add used by sat_add_sched.
// Operands are zero-extended to MAXW bits so one function serves every WIDTH.
package sat_add_pkg;

    localparam int SATCNT_W = 16;
    localparam int MAXW     = 64;

    // Returns {sat, sum}; sum occupies the low w bits, upper bits stay zero.
    function automatic logic [MAXW:0] sat_add(
        input logic [MAXW-1:0] a,
        input logic [MAXW-1:0] b,
        input int unsigned     w
    );
        logic [MAXW:0]   tmp;
        logic [MAXW-1:0] ones;
        logic            carry;
        tmp   = {1'b0, a} + {1'b0, b};
        carry = |(tmp >> w);
        ones  = {MAXW{1'b1}} >> (MAXW - w);
        return {carry, carry ? ones : tmp[MAXW-1:0]};
    endfunction

endpackage

// File: rtl/sat_add_sched_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping modulo NREQ.
module rr_arb #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        logic           found;
        logic [IDW-1:0] j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/sat_add_sched.sv
// Round-robin scheduler sharing one saturating adder between NREQ
// requesters, with a single registered response slot and saturation counter.
module sat_add_sched
    import sat_add_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 32,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_sat,
    output logic [SATCNT_W-1:0]   sat_count,
    output logic                  busy
);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            free;
    logic            take;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [MAXW:0]   res;
    logic            unused;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign free      = !rsp_valid || rsp_ready;
    assign take      = rst && free && (|req_valid);
    assign req_ready = take ? gnt : '0;
    assign busy      = rsp_valid || (|req_valid);

    assign a_sel  = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign b_sel  = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    assign res    = sat_add(MAXW'(a_sel), MAXW'(b_sel), WIDTH);
    assign unused = ^res;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_sat   <= 1'b0;
            sat_count <= '0;
        end else if (take) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_sum   <= res[WIDTH-1:0];
            rsp_sat   <= res[MAXW];
            ptr       <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            if (res[MAXW] && sat_count != '1)
                sat_count <= sat_count + 1'b1;
        end else if (free) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sat_add_sched.sv
// Self-checking bench for sat_add_sched: directed tables, hand sequences
// and randomized traffic against an arithmetic reference model.
module tb_sat_add_sched;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_sat;
    logic [15:0]       sat_count;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    int          m_ptr;
    bit          m_v;
    int          m_id;
    logic [31:0] m_sum;
    bit          m_sat;
    int          m_cnt;
    logic [NREQ-1:0] last_rdy;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        bit          sat;
        int          cnt;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    sat_add_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_sat   (rsp_sat),
        .sat_count (sat_count),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_v = 0; m_id = 0; m_sum = 0; m_sat = 0; m_cnt = 0;
    endtask

    task automatic set_op(input int i, input logic [31:0] a,
                          input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock: check handshake outputs before the edge, advance the
    // model at the edge, then check the response slot after it.
    task automatic tick();
        bit          free;
        int          g;
        longint      s;
        logic [31:0] ga, gb;
        #1;
        free = !m_v || rsp_ready;
        g = -1;
        if (rst && free)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NREQ])
                    g = (m_ptr + k) % NREQ;
        last_rdy = (g < 0) ? '0 : NREQ'(1 << g);
        chk("req_ready", req_ready, last_rdy);
        chk("busy", busy, m_v || (|req_valid));
        ga = (g < 0) ? 32'h0 : req_a[g*W +: W];
        gb = (g < 0) ? 32'h0 : req_b[g*W +: W];
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (g >= 0) begin
            s     = longint'(ga) + longint'(gb);
            m_sat = s > 64'hFFFF_FFFF;
            m_sum = m_sat ? 32'hFFFF_FFFF : s[31:0];
            m_v   = 1;
            m_id  = g;
            m_ptr = (g + 1) % NREQ;
            if (m_sat && m_cnt < 65535) m_cnt++;
        end else if (free) begin
            m_v = 0;
        end
        #1;
        chk("rsp_valid", rsp_valid, m_v);
        if (m_v) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_sum", rsp_sum, m_sum);
            chk("rsp_sat", rsp_sat, m_sat);
        end
        chk("sat_count", sat_count, m_cnt);
    endtask

    task automatic hard_reset();
        rst = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF - $urandom_range(0, 15);
            1:       return $urandom;
            2:       return $urandom_range(0, 255);
            default: return 32'h8000_0000 + $urandom_range(0, 3);
        endcase
    endfunction

    logic [31:0] held_sum;

    initial begin
        tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1, 1};
        tbl[2] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 2};
        tbl[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 2};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1, 3};
        tbl[6] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0, 3};

        rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_cnt", sat_count, 0);
        chk("rst_ready", req_ready, 0);
        rst = 1'b1;
        model_reset();

        // Single grant, then reset while the slot is held.
        req_valid = 4'b0100;
        set_op(2, 32'h7FFF_FFFF, 32'h1);
        tick();
        chk("single_id", rsp_id, 2);
        chk("single_sum", rsp_sum, 32'h8000_0000);
        chk("single_sat", rsp_sat, 0);
        req_valid = '0;
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        tick();
        rst = 1'b1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_cnt", sat_count, 0);
        rsp_ready = 1'b1;
        tick();
        chk("midrst_ptr0", rsp_id, 0);
        req_valid = 4'b1000;
        tick();
        chk("midrst_g3", rsp_id, 3);

        // Adder vectors through requester 2.
        hard_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req_valid = 4'b0100;
            set_op(2, tbl[i].a, tbl[i].b);
            tick();
            chk("tbl_sum", rsp_sum, tbl[i].sum);
            chk("tbl_sat", rsp_sat, tbl[i].sat);
            chk("tbl_cnt", sat_count, tbl[i].cnt);
        end

        // Round robin with everyone valid.
        hard_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_valid", rsp_valid, 1);
            chk("rr_id", rsp_id, i % 4);
        end

        // Backpressure, then release with ptr = 2.
        req_valid = 4'b0010;
        tick();
        chk("bp_g1", rsp_id, 1);
        held_sum = rsp_sum;
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", req_ready, 0);
            chk("bp_id", rsp_id, 1);
            chk("bp_sum", rsp_sum, held_sum);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_rel_id", rsp_id, 3);
        chk("bp_rel_valid", rsp_valid, 1);

        // Randomized traffic with operand hold while waiting.
        hard_reset();
        last_rdy = '1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] || last_rdy[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_op(i, rnd_op(), rnd_op());
                end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) != 0);
            tick();
        end
        rst = 1'b1;

        // Counter saturation.
        hard_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("cnt_65534", sat_count, 16'hFFFE);
        @(posedge clk);
        #1;
        chk("cnt_max", sat_count, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("cnt_stick", sat_count, 16'hFFFF);
        hard_reset();
        chk("cnt_clear", sat_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
